// File: rtl/seq_pkg.sv
// Encodings shared by the serial feeder and the 101 detector stage.
package seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } seq_state_t;

    // Line level the detector sees whenever no word is being shifted
    localparam logic IDLE_DEFAULT = 1'b0;

endpackage

// File: rtl/seq_hold_slot.sv
// One-entry holding buffer in front of the shifter; ready depends on registered state only.
module seq_hold_slot
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // pop only happens while full and accept only while empty, so they never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (pop) begin
            r_full <= 1'b0;
        end else if (din_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= din;
        end
    end

    assign din_ready = !r_full;
    assign data      = r_data;
    assign full      = r_full;

endmodule

// File: rtl/seq_piso_feeder.sv
// Double-buffered parallel-to-serial feeder driving the 101 detector input, one bit per clk.
module seq_piso_feeder
    import seq_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shifted;
    logic             w_head;
    logic             w_load;
    logic             w_last;
    logic             w_slot_full;
    logic [WIDTH-1:0] w_slot_data;

    seq_hold_slot #(.WIDTH(WIDTH)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .pop       (w_load),
        .data      (w_slot_data),
        .full      (w_slot_full)
    );

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_head    = r_shift[WIDTH-1];
            assign w_shifted = {r_shift[WIDTH-2:0], IDLE_BIT};
        end else begin : g_lsb
            assign w_head    = r_shift[0];
            assign w_shifted = {IDLE_BIT, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign w_last = (r_cnt == LAST_CNT);

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_slot_full) begin
                    w_load       = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Reloading on the last bit keeps back-to-back words gapless
                if (w_last) begin
                    if (w_slot_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= {WIDTH{IDLE_BIT}};
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_shift <= w_slot_data;
                r_cnt   <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_shift <= w_shifted;
                r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
            end
        end
    end

    assign sout        = (r_state == ST_SHIFT) ? w_head : IDLE_BIT;
    assign sout_valid  = (r_state == ST_SHIFT);
    assign frame_start = (r_state == ST_SHIFT) && (r_cnt == '0);
    assign busy        = w_slot_full || (r_state == ST_SHIFT);

endmodule

// File: tb/tb_seq_piso_feeder.sv
// Directed bench for seq_piso_feeder: MSB-first, LSB-first and WIDTH=2 instances side by side.
module tb_seq_piso_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0] din_a;
    logic       val_a;
    logic       rdy_a, so_a, sv_a, fs_a, bz_a;

    logic [7:0] din_b;
    logic       val_b;
    logic       rdy_b, so_b, sv_b, fs_b, bz_b;

    logic [1:0] din_c;
    logic       val_c;
    logic       rdy_c, so_c, sv_c, fs_c, bz_c;

    seq_piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(val_a), .din_ready(rdy_a),
        .sout(so_a), .sout_valid(sv_a), .frame_start(fs_a), .busy(bz_a)
    );

    seq_piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(val_b), .din_ready(rdy_b),
        .sout(so_b), .sout_valid(sv_b), .frame_start(fs_b), .busy(bz_b)
    );

    seq_piso_feeder #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .din(din_c), .din_valid(val_c), .din_ready(rdy_c),
        .sout(so_c), .sout_valid(sv_c), .frame_start(fs_c), .busy(bz_c)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ser_* hold the serial bit sequence in time order, first bit at [7]
    typedef struct {
        logic [7:0] din;
        logic [7:0] ser_msb;
        logic [7:0] ser_lsb;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] stream;
        logic [5:0]  exp6;
        logic [1:0]  w2 [3];
        int          k, nbits, first, gap;
        logic        acc;

        vecs[0] = '{din: 8'b1010_0000, ser_msb: 8'b1010_0000, ser_lsb: 8'b0000_0101};
        vecs[1] = '{din: 8'h01,        ser_msb: 8'h01,        ser_lsb: 8'h80};
        vecs[2] = '{din: 8'b0010_1010, ser_msb: 8'b0010_1010, ser_lsb: 8'b0101_0100};
        vecs[3] = '{din: 8'h1E,        ser_msb: 8'h1E,        ser_lsb: 8'h78};
        vecs[4] = '{din: 8'hC3,        ser_msb: 8'hC3,        ser_lsb: 8'hC3};

        rst = 1'b1;
        din_a = '0; val_a = 1'b0;
        din_b = '0; val_b = 1'b0;
        din_c = '0; val_c = 1'b0;
        step();
        step();
        chk("rst_ready_a", rdy_a, 1);
        chk("rst_sout_a", so_a, 0);
        chk("rst_svalid_a", sv_a, 0);
        chk("rst_fstart_a", fs_a, 0);
        chk("rst_busy_a", bz_a, 0);
        chk("rst_ready_c", rdy_c, 1);
        chk("rst_sout_b", so_b, 0);
        rst = 1'b0;
        step();

        // Single words through both 8-bit instances
        for (int i = 0; i < 5; i++) begin
            din_a = vecs[i].din; din_b = vecs[i].din;
            val_a = 1'b1;        val_b = 1'b1;
            chk("tbl_ready_c0", rdy_a, 1);
            step();
            val_a = 1'b0; val_b = 1'b0;
            din_a = 8'hFF; din_b = 8'hFF;
            chk("tbl_busy_c1", bz_a, 1);
            chk("tbl_ready_c1", rdy_a, 0);
            chk("tbl_svalid_c1", sv_a, 0);
            step();
            for (int b = 0; b < 8; b++) begin
                chk("tbl_sout_msb", so_a, vecs[i].ser_msb[7-b]);
                chk("tbl_sout_lsb", so_b, vecs[i].ser_lsb[7-b]);
                chk("tbl_svalid", sv_a, 1);
                chk("tbl_fstart_msb", fs_a, (b == 0));
                chk("tbl_fstart_lsb", fs_b, (b == 0));
                chk("tbl_busy", bz_a, 1);
                step();
            end
            chk("tbl_idle_svalid", sv_a, 0);
            chk("tbl_idle_sout", so_a, 0);
            chk("tbl_idle_busy", bz_a, 0);
            chk("tbl_idle_ready", rdy_a, 1);
            step();
        end

        // Back-to-back A5, 5A with valid held through backpressure
        stream = 16'hA55A;
        for (int c = 0; c <= 18; c++) begin
            if (c == 0) begin din_a = 8'hA5; val_a = 1'b1; end
            if (c == 1) din_a = 8'h5A;
            if (c == 3) begin val_a = 1'b0; din_a = 8'hFF; end
            if (c == 1) chk("b2b_ready_held", rdy_a, 0);
            if (c == 2) chk("b2b_ready_drain", rdy_a, 1);
            if (c >= 3 && c <= 9) chk("b2b_ready_full", rdy_a, 0);
            if (c == 10) chk("b2b_ready_reload", rdy_a, 1);
            if (c >= 2 && c <= 17) begin
                chk("b2b_svalid", sv_a, 1);
                chk("b2b_sout", so_a, stream[17-c]);
                chk("b2b_fstart", fs_a, (c == 2 || c == 10));
            end
            if (c == 18) begin
                chk("b2b_end_svalid", sv_a, 0);
                chk("b2b_end_busy", bz_a, 0);
            end
            step();
        end

        // Reset held two cycles in the middle of a word
        din_a = 8'hC3; val_a = 1'b1;
        step();
        val_a = 1'b0;
        step();
        step();
        step();
        step();
        chk("mid_svalid", sv_a, 1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("mrst_sout", so_a, 0);
        chk("mrst_svalid", sv_a, 0);
        chk("mrst_ready", rdy_a, 1);
        chk("mrst_busy", bz_a, 0);
        chk("mrst_fstart", fs_a, 0);
        for (int j = 0; j < 3; j++) begin
            step();
            chk("mrst_discard", sv_a, 0);
        end

        // WIDTH=2 stream of three words must stay gapless
        w2[0] = 2'b10; w2[1] = 2'b01; w2[2] = 2'b11;
        exp6 = 6'b100111;
        k = 0; nbits = 0; first = -1; gap = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            din_c = (k < 3) ? w2[k] : 2'b00;
            val_c = (k < 3);
            acc   = val_c && rdy_c;
            if (sv_c) begin
                if (nbits < 6) begin
                    chk("w2_sout", so_c, exp6[5-nbits]);
                    chk("w2_fstart", fs_c, (nbits % 2 == 0));
                end
                if (first < 0) first = cyc;
                else if (cyc != first + nbits) gap = 1;
                nbits++;
            end
            step();
            if (acc) k++;
        end
        val_c = 1'b0;
        chk("w2_nbits", nbits, 6);
        chk("w2_gap", gap, 0);
        chk("w2_first", first, 2);
        chk("w2_words", k, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
